// File: rtl/data_ram_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// data_ram_pkg
// Shared definitions for the data RAM arbiter slice:
//   - arb_state_e : arbiter FSM states (IDLE/ISSUE/WAIT/ACK)
//   - ADDR_W_DEF / DATA_W_DEF : default address / data widths
//   - PORT_CPU / PORT_LDR     : requester port indices (load/store unit, loader)
// ---------------------------------------------------------------------------
package data_ram_pkg;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned DATA_W_DEF = 8;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } arb_state_e;

endpackage

// File: rtl/data_ram_arbiter_if.sv
// ---------------------------------------------------------------------------
// data_ram_arbiter_if
// Bundles the two requester handshakes and the RAM-side bus of the arbiter.
//   p0_* : CPU load/store unit port   (req/we/addr/wdata in, ack/rdata out)
//   p1_* : program/data loader port   (req/we/addr/wdata in, ack/rdata out)
//   ram_data_w/ram_addr/ram_din : arbiter -> RAM, ram_dout : RAM -> arbiter
//   arb_busy : arbiter not in IDLE
// Modports:
//   slave  : the arbiter's view
//   master : the environment's view (requesters + RAM)
// ---------------------------------------------------------------------------
interface data_ram_arbiter_if
    import data_ram_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
);

    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_ack;
    logic [DATA_W-1:0] p0_rdata;

    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_ack;
    logic [DATA_W-1:0] p1_rdata;

    logic              ram_data_w;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    logic              arb_busy;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        input  ram_dout,
        output p0_ack, p0_rdata, p1_ack, p1_rdata,
        output ram_data_w, ram_addr, ram_din,
        output arb_busy
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        output ram_dout,
        input  p0_ack, p0_rdata, p1_ack, p1_rdata,
        input  ram_data_w, ram_addr, ram_din,
        input  arb_busy
    );

endinterface

// File: rtl/data_ram_arb_pick.sv
// ---------------------------------------------------------------------------
// data_ram_arb_pick
// Combinational winner select for the two-port data RAM arbiter.
// Ports:
//   req_i[1:0]    : request from port 1 (bit 1) and port 0 (bit 0)
//   last_grant_i  : port granted most recently
//   valid_o       : at least one request present
//   grant_o       : winning port index (PORT_CPU / PORT_LDR)
// Configuration macro: DATA_ARB_RR_EN
//   defined   -> round-robin on a tie (port other than last_grant_i wins)
//   undefined -> fixed priority on a tie (port 0 wins)
// ---------------------------------------------------------------------------
module data_ram_arb_pick
    import data_ram_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       valid_o,
    output logic       grant_o
);

`ifndef DATA_ARB_RR_EN
    // Grant history is kept by the caller but does not steer fixed priority.
    logic unused_last_grant;
    assign unused_last_grant = last_grant_i;
`endif

    always_comb begin
        valid_o = |req_i;
        grant_o = PORT_CPU;
        if (req_i == 2'b10) begin
            grant_o = PORT_LDR;
        end else if (req_i == 2'b11) begin
`ifdef DATA_ARB_RR_EN
            grant_o = ~last_grant_i;
`else
            grant_o = PORT_CPU;
`endif
        end
    end

endmodule

// File: rtl/data_ram_arbiter.sv
// ---------------------------------------------------------------------------
// data_ram_arbiter
// Serialises CPU (port 0) and loader (port 1) accesses to the single-port,
// synchronous-read data RAM. Each access walks IDLE -> ISSUE -> WAIT -> ACK:
// request sampled in IDLE, RAM operates at the end of ISSUE, registered read
// data captured at the end of WAIT, one-cycle ack during ACK.
// Ports:
//   clk_in : clock, rising edge
//   rst    : synchronous active-high reset
//   bus    : data_ram_arbiter_if.slave (requester handshakes + RAM bus)
// Configuration macro: DATA_ARB_RR_EN (tie-break policy, see data_ram_arb_pick)
// ---------------------------------------------------------------------------
module data_ram_arbiter
    import data_ram_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input logic               clk_in,
    input logic               rst,
    data_ram_arbiter_if.slave bus
);

    arb_state_e        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              grant_q, grant_d;
    logic              we_q, we_d;
    logic              data_w_q, data_w_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic              pick_valid;
    logic              pick_grant;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_din;

    data_ram_arb_pick u_pick (
        .req_i        ({bus.p1_req, bus.p0_req}),
        .last_grant_i (last_grant_q),
        .valid_o      (pick_valid),
        .grant_o      (pick_grant)
    );

    assign sel_we   = (pick_grant == PORT_LDR) ? bus.p1_we    : bus.p0_we;
    assign sel_addr = (pick_grant == PORT_LDR) ? bus.p1_addr  : bus.p0_addr;
    assign sel_din  = (pick_grant == PORT_LDR) ? bus.p1_wdata : bus.p0_wdata;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        we_d         = we_q;
        data_w_d     = 1'b0;    // write strobe only ever lives for ISSUE
        addr_d       = addr_q;  // address held between accesses: idle reads are harmless
        din_d        = din_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d      = pick_grant;
                    last_grant_d = pick_grant;
                    we_d         = sel_we;
                    data_w_d     = sel_we;
                    addr_d       = sel_addr;
                    din_d        = sel_din;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                // RAM output register now holds the addressed word.
                if (grant_q == PORT_LDR) begin
                    ack1_d = 1'b1;
                    if (!we_q) rdata1_d = bus.ram_dout;
                end else begin
                    ack0_d = 1'b1;
                    if (!we_q) rdata0_d = bus.ram_dout;
                end
                state_d = ACK;
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= PORT_LDR;
            grant_q      <= PORT_CPU;
            we_q         <= 1'b0;
            data_w_q     <= 1'b0;
            addr_q       <= '0;
            din_q        <= '0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            we_q         <= we_d;
            data_w_q     <= data_w_d;
            addr_q       <= addr_d;
            din_q        <= din_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    assign bus.ram_data_w = data_w_q;
    assign bus.ram_addr   = addr_q;
    assign bus.ram_din    = din_q;
    assign bus.p0_ack     = ack0_q;
    assign bus.p1_ack     = ack1_q;
    assign bus.p0_rdata   = rdata0_q;
    assign bus.p1_rdata   = rdata1_q;
    assign bus.arb_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_data_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_data_ram_arbiter
// Bench for data_ram_arbiter with a behavioural data RAM (preloaded with
// 3*addr+10, so address 0 holds 10). Tie-break expectations follow
// DATA_ARB_RR_EN when the bench is built with it.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_data_ram_arbiter;
    import data_ram_pkg::*;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;
    localparam int unsigned RAND_CYCLES = 3000;

    logic clk_in = 1'b0;
    logic rst;
    always #5 clk_in = ~clk_in;

    data_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    data_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus)
    );

    // Behavioural synchronous-read RAM (read-first).
    logic [DW-1:0] ram_mem [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];

    function automatic logic [DW-1:0] preload(input int unsigned a);
        return 8'((a * 3 + 10) & 255);
    endfunction

    initial begin
        for (int unsigned i = 0; i < (1 << AW); i++) begin
            ram_mem[i] = preload(i);
            ref_mem[i] = preload(i);
        end
    end

    always @(posedge clk_in) begin
        bus.ram_dout <= ram_mem[bus.ram_addr];
        if (bus.ram_data_w) ram_mem[bus.ram_addr] = bus.ram_din;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = '0; bus.p0_wdata = '0;
        bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = '0; bus.p1_wdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        @(posedge clk_in); #1;
        @(posedge clk_in); #1;
        rst = 1'b0;
    endtask

    task automatic set_port(input logic port, input logic we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wd);
        if (port) begin
            bus.p1_req = 1'b1; bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wd;
        end else begin
            bus.p0_req = 1'b1; bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wd;
        end
    endtask

    // One access from an idle arbiter; returns ack latency (-1 on timeout),
    // write-strobe cycles seen and acks seen on the other port.
    task automatic single(input logic port, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, output int lat, output int wcnt,
                          output int other);
        lat = -1; wcnt = 0; other = 0;
        set_port(port, we, addr, wd);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk_in); #1;
            if (bus.ram_data_w) wcnt++;
            if (port ? bus.p0_ack : bus.p1_ack) other++;
            if (port ? bus.p1_ack : bus.p0_ack) begin
                lat = k;
                break;
            end
        end
        bus.p0_req = 1'b0;
        bus.p1_req = 1'b0;
        @(posedge clk_in); #1;
    endtask

    typedef struct {
        logic          port;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rd0;
        logic [DW-1:0] exp_rd1;
    } vec_t;

    vec_t tbl [0:8];

    // Reference model: winner choice from the arbitration rules.
    function automatic logic model_pick(input logic r0, input logic r1, input logic last);
        if (r0 && !r1) return 1'b0;
        if (r1 && !r0) return 1'b1;
`ifdef DATA_ARB_RR_EN
        return !last;
`else
        return (last & 1'b0);
`endif
    endfunction

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, wcnt, other, lat0, lat1, n0, n1;
        logic exp0 [1:24];
        logic exp1 [1:24];

        // ---------------- reset values ----------------
        do_reset();
        chk("rst_p0_ack", 32'(bus.p0_ack), 0);
        chk("rst_p1_ack", 32'(bus.p1_ack), 0);
        chk("rst_busy", 32'(bus.arb_busy), 0);
        chk("rst_data_w", 32'(bus.ram_data_w), 0);
        chk("rst_addr", 32'(bus.ram_addr), 0);
        chk("rst_din", 32'(bus.ram_din), 0);
        chk("rst_p0_rdata", 32'(bus.p0_rdata), 0);
        chk("rst_p1_rdata", 32'(bus.p1_rdata), 0);

        // ---------------- table-driven single accesses ----------------
        tbl[0] = '{1'b0, 1'b1, 16'h0003, 8'hA5, 8'h00, 8'h00};
        tbl[1] = '{1'b0, 1'b0, 16'h0003, 8'h00, 8'hA5, 8'h00};
        tbl[2] = '{1'b1, 1'b0, 16'h0000, 8'h00, 8'hA5, 8'h0A};
        tbl[3] = '{1'b1, 1'b1, 16'h0005, 8'h66, 8'hA5, 8'h0A};
        tbl[4] = '{1'b0, 1'b0, 16'h0005, 8'h00, 8'h66, 8'h0A};
        tbl[5] = '{1'b1, 1'b0, 16'hFFFF, 8'h00, 8'h66, 8'h07};
        tbl[6] = '{1'b0, 1'b1, 16'hFFFF, 8'h5A, 8'h66, 8'h07};
        tbl[7] = '{1'b1, 1'b0, 16'hFFFF, 8'h00, 8'h66, 8'h5A};
        tbl[8] = '{1'b0, 1'b0, 16'h0001, 8'h00, 8'h0D, 8'h5A};
        for (int i = 0; i <= 8; i++) begin
            single(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, lat, wcnt, other);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 3);
            chk($sformatf("vec%0d_write_strobes", i), 32'(wcnt), 32'(tbl[i].we));
            chk($sformatf("vec%0d_other_ack", i), 32'(other), 0);
            chk($sformatf("vec%0d_p0_rdata", i), 32'(bus.p0_rdata), 32'(tbl[i].exp_rd0));
            chk($sformatf("vec%0d_p1_rdata", i), 32'(bus.p1_rdata), 32'(tbl[i].exp_rd1));
        end

        // ---------------- reset during WAIT of a read ----------------
        set_port(1'b0, 1'b0, 16'h0003, 8'h00);
        @(posedge clk_in); #1;          // ISSUE
        @(posedge clk_in); #1;          // WAIT
        rst = 1'b1;
        @(posedge clk_in); #1;
        chk("rstwait_p0_ack", 32'(bus.p0_ack), 0);
        chk("rstwait_p1_ack", 32'(bus.p1_ack), 0);
        chk("rstwait_busy", 32'(bus.arb_busy), 0);
        chk("rstwait_data_w", 32'(bus.ram_data_w), 0);
        chk("rstwait_addr", 32'(bus.ram_addr), 0);
        chk("rstwait_p0_rdata", 32'(bus.p0_rdata), 0);
        chk("rstwait_p1_rdata", 32'(bus.p1_rdata), 0);
        rst = 1'b0;
        lat = -1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk_in); #1;
            if (bus.p0_ack) begin lat = k; break; end
        end
        chk("rstwait_reissue_latency", 32'(lat), 3);
        chk("rstwait_reissue_rdata", 32'(bus.p0_rdata), 32'h A5);
        clear_inputs();
        @(posedge clk_in); #1;

        // ---------------- both requests held ----------------
        do_reset();
        for (int k = 1; k <= 24; k++) begin exp0[k] = 1'b0; exp1[k] = 1'b0; end
`ifdef DATA_ARB_RR_EN
        exp0[3] = 1'b1; exp1[7] = 1'b1; exp0[11] = 1'b1; exp1[15] = 1'b1;
        exp0[19] = 1'b1; exp0[23] = 1'b1;
`else
        exp0[3] = 1'b1; exp0[7] = 1'b1; exp0[11] = 1'b1; exp0[15] = 1'b1;
        exp1[19] = 1'b1; exp1[23] = 1'b1;
`endif
        n0 = 0; n1 = 0;
        set_port(1'b0, 1'b0, 16'h0003, 8'h00);
        set_port(1'b1, 1'b0, 16'h0000, 8'h00);
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk_in); #1;
            chk($sformatf("both_c%0d_p0_ack", k), 32'(bus.p0_ack), 32'(exp0[k]));
            chk($sformatf("both_c%0d_p1_ack", k), 32'(bus.p1_ack), 32'(exp1[k]));
            if (bus.p0_ack) begin n0++; if (n0 == 4) bus.p0_req = 1'b0; end
            if (bus.p1_ack) begin n1++; if (n1 == 2) bus.p1_req = 1'b0; end
        end
        chk("both_p0_rdata", 32'(bus.p0_rdata), 32'h A5);
        chk("both_p1_rdata", 32'(bus.p1_rdata), 32'h 0A);
        clear_inputs();
        @(posedge clk_in); #1;

        // ---------------- write with a read of the same address pending ----------------
        do_reset();
        single(1'b0, 1'b0, 16'h0003, 8'h00, lat, wcnt, other);
        chk("pend_pre_p0_rdata", 32'(bus.p0_rdata), 32'h A5);
        lat0 = -1; lat1 = -1;
        set_port(1'b0, 1'b1, 16'h0005, 8'h3C);
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk_in); #1;
            if (k == 1) set_port(1'b1, 1'b0, 16'h0005, 8'h00);
            if (bus.p0_ack) begin lat0 = k; bus.p0_req = 1'b0; end
            if (bus.p1_ack) begin lat1 = k; bus.p1_req = 1'b0; break; end
        end
        chk("pend_p0_ack_cycle", 32'(lat0), 3);
        chk("pend_p1_ack_cycle", 32'(lat1), 7);
        chk("pend_p1_rdata", 32'(bus.p1_rdata), 32'h 3C);
        chk("pend_p0_rdata_kept", 32'(bus.p0_rdata), 32'h A5);
        clear_inputs();
        @(posedge clk_in); #1;

        // ---------------- randomized traffic vs. transaction-level model ----------------
        // Addresses confined to 0x100..0x10F, untouched above, so ref_mem is exact.
        begin
            int next_s, g_e;
            logic g_port, g_we, m_last;
            logic [AW-1:0] g_addr;
            logic [DW-1:0] g_din, g_rd, m_rd0, m_rd1;
            logic e_ack0, e_ack1, e_busy, e_dw;

            do_reset();
            next_s = 1; g_e = -100; m_last = 1'b1;
            g_port = 1'b0; g_we = 1'b0; g_addr = '0; g_din = '0; g_rd = '0;
            m_rd0 = '0; m_rd1 = '0;
            for (int e = 1; e <= int'(RAND_CYCLES); e++) begin
                @(posedge clk_in); #1;
                if (e == next_s) begin
                    if (bus.p0_req || bus.p1_req) begin
                        g_port = model_pick(bus.p0_req, bus.p1_req, m_last);
                        m_last = g_port;
                        g_e    = e;
                        g_we   = g_port ? bus.p1_we : bus.p0_we;
                        g_addr = g_port ? bus.p1_addr : bus.p0_addr;
                        g_din  = g_port ? bus.p1_wdata : bus.p0_wdata;
                        if (g_we) ref_mem[g_addr] = g_din;
                        else      g_rd = ref_mem[g_addr];
                        next_s = e + 4;
                    end else begin
                        next_s = e + 1;
                    end
                end
                e_busy = (e >= g_e) && (e <= g_e + 2);
                e_dw   = (e == g_e) && g_we;
                e_ack0 = (e == g_e + 2) && !g_port;
                e_ack1 = (e == g_e + 2) && g_port;
                if (e_ack0 && !g_we) m_rd0 = g_rd;
                if (e_ack1 && !g_we) m_rd1 = g_rd;

                chk("rand_p0_ack", 32'(bus.p0_ack), 32'(e_ack0));
                chk("rand_p1_ack", 32'(bus.p1_ack), 32'(e_ack1));
                chk("rand_busy", 32'(bus.arb_busy), 32'(e_busy));
                chk("rand_data_w", 32'(bus.ram_data_w), 32'(e_dw));
                chk("rand_p0_rdata", 32'(bus.p0_rdata), 32'(m_rd0));
                chk("rand_p1_rdata", 32'(bus.p1_rdata), 32'(m_rd1));
                if (e == g_e) begin
                    chk("rand_ram_addr", 32'(bus.ram_addr), 32'(g_addr));
                    if (g_we) chk("rand_ram_din", 32'(bus.ram_din), 32'(g_din));
                end

                // Requesters: hold until acked, then optionally re-request.
                if (e_ack0) begin
                    if ($urandom_range(0, 1) == 1)
                        set_port(1'b0, 1'($urandom_range(0, 1)), 16'(16'h0100 + $urandom_range(0, 15)), 8'($urandom));
                    else bus.p0_req = 1'b0;
                end else if (!bus.p0_req && $urandom_range(0, 2) == 0) begin
                    set_port(1'b0, 1'($urandom_range(0, 1)), 16'(16'h0100 + $urandom_range(0, 15)), 8'($urandom));
                end
                if (e_ack1) begin
                    if ($urandom_range(0, 1) == 1)
                        set_port(1'b1, 1'($urandom_range(0, 1)), 16'(16'h0100 + $urandom_range(0, 15)), 8'($urandom));
                    else bus.p1_req = 1'b0;
                end else if (!bus.p1_req && $urandom_range(0, 2) == 0) begin
                    set_port(1'b1, 1'($urandom_range(0, 1)), 16'(16'h0100 + $urandom_range(0, 15)), 8'($urandom));
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
